// File: rtl/ib_uart_bridge_if.sv
// Byte-stream and IB expander handshake bundle for ib_uart_bridge.
// slave = bridge side, master = UART/meter environment side.
interface ib_uart_bridge_if;
    logic [7:0] uart_rx_data;
    logic       uart_rx_valid;
    logic       uart_rx_ready;
    logic [7:0] uart_tx_data;
    logic       uart_tx_valid;
    logic       uart_tx_ready;
    logic [7:0] ib_tx_data;
    logic       ib_tx_data_available;
    logic       ib_tx_data_ack_n;
    logic [7:0] ib_rx_data;
    logic       ib_rx_data_available;
    logic       ib_tx_ack;

    modport slave (
        input  uart_rx_data, uart_rx_valid, uart_tx_ready,
        input  ib_tx_data_ack_n, ib_rx_data, ib_rx_data_available,
        output uart_rx_ready, uart_tx_data, uart_tx_valid,
        output ib_tx_data, ib_tx_data_available, ib_tx_ack
    );

    modport master (
        output uart_rx_data, uart_rx_valid, uart_tx_ready,
        output ib_tx_data_ack_n, ib_rx_data, ib_rx_data_available,
        input  uart_rx_ready, uart_tx_data, uart_tx_valid,
        input  ib_tx_data, ib_tx_data_available, ib_tx_ack
    );
endinterface

// File: rtl/ib_uart_bridge.sv
// UART <-> IB expander bridge: host->meter FIFO plus two independent 4-phase handshake FSMs.
// Defining IB_ACK_TIMEOUT_EN adds a per-handshake watchdog and the sticky ib_timeout flag.
//
// state     | meaning
// D_IDLE    | waiting for a queued byte; loads ib_tx_data from FIFO head
// D_OFFER   | ib_tx_data_available high, waiting for ack_n low
// D_RELEASE | byte popped, waiting for ack_n to return high
// U_IDLE    | waiting for meter byte; captures ib_rx_data on avail
// U_SEND    | uart_tx_valid high until the transmitter takes it
// U_ACK     | ib_tx_ack high until the meter drops available
module ib_uart_bridge #(
    parameter int FIFO_DEPTH     = 16,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 800000
) (
    input  logic            clk,
    input  logic            rst,
    ib_uart_bridge_if.slave bus,
    output logic            overflow,
    output logic            ib_timeout
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {D_IDLE, D_OFFER, D_RELEASE} d_state_t;
    typedef enum logic [1:0] {U_IDLE, U_SEND, U_ACK} u_state_t;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        SYNC_STAGES < 1 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("ib_uart_bridge: illegal parameter combination");
    end

    // Reset values match the expander idle levels so no phantom edge is seen.
    logic [SYNC_STAGES-1:0] ack_n_sync, avail_sync;
    logic ack_n_s, avail_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_n_sync <= '1;
            avail_sync <= '0;
        end else begin
            ack_n_sync[0] <= bus.ib_tx_data_ack_n;
            avail_sync[0] <= bus.ib_rx_data_available;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                ack_n_sync[i] <= ack_n_sync[i-1];
                avail_sync[i] <= avail_sync[i-1];
            end
        end
    end

    assign ack_n_s = ack_n_sync[SYNC_STAGES-1];
    assign avail_s = avail_sync[SYNC_STAGES-1];

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full, empty, push, pop;

    assign full  = (count == CW'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign push  = bus.uart_rx_valid & ~full;
    assign bus.uart_rx_ready = ~full;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.uart_rx_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
            if (bus.uart_rx_valid && full) overflow <= 1'b1;
        end
    end

    d_state_t   d_state, d_state_next;
    u_state_t   u_state, u_state_next;
    logic       d_load, u_capture, d_expire, u_expire;
    logic [7:0] ib_tx_data_q, uart_tx_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            d_state        <= D_IDLE;
            u_state        <= U_IDLE;
            ib_tx_data_q   <= '0;
            uart_tx_data_q <= '0;
        end else begin
            d_state <= d_state_next;
            u_state <= u_state_next;
            if (d_load)    ib_tx_data_q   <= mem[rd_ptr];
            if (u_capture) uart_tx_data_q <= bus.ib_rx_data;
        end
    end

    always_comb begin
        d_state_next = d_state;
        d_load       = 1'b0;
        pop          = 1'b0;
        unique case (d_state)
            D_IDLE: if (!empty) begin
                d_load       = 1'b1;
                d_state_next = D_OFFER;
            end
            D_OFFER: if (!ack_n_s) begin
                pop          = 1'b1;
                d_state_next = D_RELEASE;
            end else if (d_expire) begin
                pop          = 1'b1;
                d_state_next = D_IDLE;
            end
            D_RELEASE: if (ack_n_s || d_expire) d_state_next = D_IDLE;
            default: d_state_next = D_IDLE;
        endcase
    end

    always_comb begin
        u_state_next = u_state;
        u_capture    = 1'b0;
        unique case (u_state)
            U_IDLE: if (avail_s) begin
                u_capture    = 1'b1;
                u_state_next = U_SEND;
            end
            U_SEND:  if (bus.uart_tx_ready) u_state_next = U_ACK;
            U_ACK:   if (!avail_s || u_expire) u_state_next = U_IDLE;
            default: u_state_next = U_IDLE;
        endcase
    end

    assign bus.ib_tx_data           = ib_tx_data_q;
    assign bus.ib_tx_data_available = (d_state == D_OFFER);
    assign bus.uart_tx_data         = uart_tx_data_q;
    assign bus.uart_tx_valid        = (u_state == U_SEND);
    assign bus.ib_tx_ack            = (u_state == U_ACK);

`ifdef IB_ACK_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYCLES - 1);

    // Down-counters reload on every state change; terminal count means expiry.
    logic [TW-1:0] d_tmr, u_tmr;

    always_ff @(posedge clk) begin
        if (rst) begin
            d_tmr      <= TMR_LOAD;
            u_tmr      <= TMR_LOAD;
            ib_timeout <= 1'b0;
        end else begin
            if (d_state_next != d_state)                d_tmr <= TMR_LOAD;
            else if (d_state != D_IDLE && d_tmr != '0) d_tmr <= d_tmr - TW'(1);
            if (u_state_next != u_state)               u_tmr <= TMR_LOAD;
            else if (u_state == U_ACK && u_tmr != '0)  u_tmr <= u_tmr - TW'(1);
            if (d_expire || u_expire) ib_timeout <= 1'b1;
        end
    end

    assign d_expire = (d_state != D_IDLE) && (d_tmr == '0);
    assign u_expire = (u_state == U_ACK) && (u_tmr == '0);
`else
    assign d_expire   = 1'b0;
    assign u_expire   = 1'b0;
    assign ib_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_ib_uart_bridge.sv
// Self-checking bench for ib_uart_bridge: meter model + scoreboards, upstream vector table.
`timescale 1ns/1ps
module tb_ib_uart_bridge;
    localparam int FIFO_DEPTH     = 16;
    localparam int SYNC_STAGES    = 2;
    localparam int TIMEOUT_CYCLES = 50;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic overflow, ib_timeout;

    ib_uart_bridge_if bus();

    ib_uart_bridge #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .SYNC_STAGES(SYNC_STAGES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .overflow(overflow),
        .ib_timeout(ib_timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_dn[$];
    logic [7:0] exp_up[$];
    bit meter_en     = 1'b0;
    bit meter_busy   = 1'b0;
    int dn_delivered = 0;

    typedef struct {
        logic [7:0] rx_byte;
        int         ready_delay;
        logic [7:0] exp_tx_data;
    } up_vec_t;
    up_vec_t up_tbl[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b, input bit exp_accept);
        bus.uart_rx_data  = b;
        bus.uart_rx_valid = 1'b1;
        check("rx_ready", bus.uart_rx_ready, exp_accept);
        if (exp_accept) exp_dn.push_back(b);
        tick();
        bus.uart_rx_valid = 1'b0;
    endtask

    task automatic wait_dn_idle();
        int k = 0;
        while ((exp_dn.size() != 0 || meter_busy) && k < 3000) begin
            tick();
            k++;
        end
        check("dn_drain", (exp_dn.size() == 0 && !meter_busy), 1);
    endtask

    task automatic up_xfer(input logic [7:0] d, input int ready_delay, input logic [7:0] exp_d);
        int k = 0;
        logic [7:0] e;
        exp_up.push_back(exp_d);
        bus.ib_rx_data           = d;
        bus.ib_rx_data_available = 1'b1;
        while (!bus.uart_tx_valid && k < 20) begin
            tick();
            k++;
        end
        check("up_valid_seen", bus.uart_tx_valid, 1);
        e = exp_up.pop_front();
        check("up_data", bus.uart_tx_data, e);
        for (int i = 0; i < ready_delay; i++) begin
            check("up_hold_valid", bus.uart_tx_valid, 1);
            check("up_hold_data", bus.uart_tx_data, e);
            check("up_hold_no_ack", bus.ib_tx_ack, 0);
            tick();
        end
        bus.uart_tx_ready = 1'b1;
        tick();
        bus.uart_tx_ready = 1'b0;
        check("up_ack_high", bus.ib_tx_ack, 1);
        check("up_valid_low", bus.uart_tx_valid, 0);
        bus.ib_rx_data_available = 1'b0;
        tick();
        check("up_ack_until_sync", bus.ib_tx_ack, 1);
        k = 0;
        while (bus.ib_tx_ack && k < 8) begin
            tick();
            k++;
        end
        check("up_ack_release", bus.ib_tx_ack, 0);
        check("up_valid_after", bus.uart_tx_valid, 0);
    endtask

    // Meter model: ack_n low 4 cycles after an offer, high 4 cycles after it is withdrawn.
    initial begin : meter_model
        logic [7:0] b;
        int k;
        forever begin
            tick();
            if (meter_en && bus.ib_tx_data_available && bus.ib_tx_data_ack_n) begin
                meter_busy = 1'b1;
                b = bus.ib_tx_data;
                if (exp_dn.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL dn_unexpected: got %02h, expected no byte", b);
                end else begin
                    check("dn_order", b, exp_dn.pop_front());
                end
                for (int i = 0; i < 4; i++) begin
                    tick();
                    check("dn_avail_hold", bus.ib_tx_data_available, 1);
                    check("dn_stable", bus.ib_tx_data, b);
                end
                bus.ib_tx_data_ack_n = 1'b0;
                k = 0;
                while (bus.ib_tx_data_available && k < 30) begin
                    check("dn_stable", bus.ib_tx_data, b);
                    tick();
                    k++;
                end
                check("dn_release", bus.ib_tx_data_available, 0);
                for (int i = 0; i < 4; i++) tick();
                bus.ib_tx_data_ack_n = 1'b1;
                dn_delivered++;
                meter_busy = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    initial begin : main
        int k;
        int base;
        bit seen;

        up_tbl[0] = '{8'h5A, 10, 8'h5A};
        up_tbl[1] = '{8'h00, 0,  8'h00};
        up_tbl[2] = '{8'hFF, 1,  8'hFF};
        up_tbl[3] = '{8'h81, 3,  8'h81};

        bus.uart_rx_data         = '0;
        bus.uart_rx_valid        = 1'b0;
        bus.uart_tx_ready        = 1'b0;
        bus.ib_tx_data_ack_n     = 1'b1;
        bus.ib_rx_data           = '0;
        bus.ib_rx_data_available = 1'b0;

        rst = 1'b1;
        repeat (3) tick();
        check("rst_rx_ready", bus.uart_rx_ready, 1);
        check("rst_tx_valid", bus.uart_tx_valid, 0);
        check("rst_tx_data", bus.uart_tx_data, 0);
        check("rst_ib_avail", bus.ib_tx_data_available, 0);
        check("rst_ib_data", bus.ib_tx_data, 0);
        check("rst_ib_ack", bus.ib_tx_ack, 0);
        check("rst_overflow", overflow, 0);
        check("rst_timeout", ib_timeout, 0);
        rst = 1'b0;
        tick();

        // Two bytes in order through the meter handshake
        meter_en = 1'b1;
        push_byte(8'hA5, 1);
        push_byte(8'h3C, 1);
        wait_dn_idle();
        check("t1_delivered", dn_delivered, 2);
        check("t1_overflow", overflow, 0);
        check("t1_rx_ready", bus.uart_rx_ready, 1);

        // Upstream vectors, including a long uart_tx_ready stall
        foreach (up_tbl[i]) up_xfer(up_tbl[i].rx_byte, up_tbl[i].ready_delay, up_tbl[i].exp_tx_data);

        // Both directions at once
        base = dn_delivered;
        fork
            push_byte(8'h11, 1);
            up_xfer(8'h22, 2, 8'h22);
        join
        wait_dn_idle();
        check("conc_delivered", dn_delivered - base, 1);

        // Overflow: 17 back-to-back pushes with the meter silent
        meter_en = 1'b0;
        base = dn_delivered;
        for (int i = 1; i <= 16; i++) push_byte(8'h40 + 8'(i), 1);
        check("ovf_before", overflow, 0);
        push_byte(8'h51, 0);
        check("ovf_set", overflow, 1);
        check("ovf_ready_low", bus.uart_rx_ready, 0);
        meter_en = 1'b1;
        wait_dn_idle();
        check("ovf_delivered", dn_delivered - base, 16);
        check("ovf_sticky", overflow, 1);

        // Reset during D_OFFER with 3 bytes queued
        meter_en = 1'b0;
        repeat (12) tick();
        push_byte(8'h71, 1);
        push_byte(8'h72, 1);
        push_byte(8'h73, 1);
        k = 0;
        while (!bus.ib_tx_data_available && k < 10) begin
            tick();
            k++;
        end
        check("rst2_offer_seen", bus.ib_tx_data_available, 1);
        rst = 1'b1;
        tick();
        check("rst2_avail", bus.ib_tx_data_available, 0);
        check("rst2_rx_ready", bus.uart_rx_ready, 1);
        check("rst2_ib_data", bus.ib_tx_data, 0);
        check("rst2_overflow", overflow, 0);
        rst = 1'b0;
        exp_dn.delete();
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.ib_tx_data_available) seen = 1'b1;
        end
        check("rst2_nothing_offered", seen, 0);
        check("rst2_ready_after", bus.uart_rx_ready, 1);

`ifdef IB_ACK_TIMEOUT_EN
        push_byte(8'h91, 1);
        push_byte(8'h92, 1);
        exp_dn.delete();
        k = 0;
        while (!bus.ib_tx_data_available && k < 10) begin
            tick();
            k++;
        end
        check("to_offer_seen", bus.ib_tx_data_available, 1);
        k = 0;
        while (bus.ib_tx_data_available && k < 200) begin
            k++;
            tick();
        end
        check("to_offer_len", k, TIMEOUT_CYCLES);
        check("to_flag", ib_timeout, 1);
        k = 0;
        while (!bus.ib_tx_data_available && k < 10) begin
            tick();
            k++;
        end
        check("to_next_offer", bus.ib_tx_data_available, 1);
        check("to_next_data", bus.ib_tx_data, 8'h92);
`else
        check("no_timeout_flag", ib_timeout, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ib_uart_bridge.md
Name: ib_uart_bridge

Overview:
- Clock-domain bridge between the UART byte streams and the IB I/O-expander byte interface (the prog_n-clocked expander stage).
- Buffers host->meter bytes in a FIFO and offers them one at a time over a 4-phase handshake.
- Captures meter->host bytes over a second 4-phase handshake and forwards them to the UART transmitter.
- All IB-side inputs are asynchronous to clk and are synchronized inside this block.

Parameters:
- FIFO_DEPTH, 16, host->meter FIFO entries; power of 2, >= 2.
- SYNC_STAGES, 2, flip-flop stages on each IB-side control input.
- TIMEOUT_CYCLES, 800000, handshake watchdog limit in clk cycles (100 ms at 8 MHz); used only with IB_ACK_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, 8 MHz.
- rst  in  1  synchronous reset, active-high.
- uart_rx_data  in  8  byte from the UART receiver.
- uart_rx_valid  in  1  uart_rx_data valid this cycle.
- uart_rx_ready  out  1  FIFO can accept a byte.
- uart_tx_data  out  8  byte to the UART transmitter.
- uart_tx_valid  out  1  uart_tx_data valid.
- uart_tx_ready  in  1  transmitter accepts the byte.
- ib_tx_data  out  8  byte offered to the meter.
- ib_tx_data_available  out  1  offer strobe.
- ib_tx_data_ack_n  in  1  meter acknowledge, active-low, asynchronous.
- ib_rx_data  in  8  byte from the meter, asynchronous; stable while ib_rx_data_available=1.
- ib_rx_data_available  in  1  meter byte ready, asynchronous.
- ib_tx_ack  out  1  byte-taken acknowledge to the meter.
- overflow  out  1  sticky: a byte was dropped because the FIFO was full.
- ib_timeout  out  1  sticky watchdog flag; tied 0 without IB_ACK_TIMEOUT_EN.

Behaviour:
- Reset: all outputs 0 except uart_rx_ready; FIFO emptied; both FSMs return to idle; sticky flags cleared.
- Synchronizer reset values: ack_n_s=1, avail_s=0, matching the expander's idle levels.
- Synchronizer latency: SYNC_STAGES cycles on ib_tx_data_ack_n and ib_rx_data_available.
- Reset mid-handshake: outputs drop immediately and the FIFO contents are discarded.

FIFO:
- Push when uart_rx_valid & uart_rx_ready.
- uart_rx_ready = ~full (combinational from the count); it is therefore 1 after reset.
- uart_rx_valid while full: byte dropped, overflow<=1.
- Count width is $clog2(FIFO_DEPTH+1); pointers wrap modulo FIFO_DEPTH.
- A pop and a push in the same cycle are both legal when not full; count is unchanged.

Downstream FSM (host->meter):
- D_IDLE: if the FIFO is not empty, load ib_tx_data from the head, go to D_OFFER.
- D_OFFER: ib_tx_data_available=1. On ack_n_s==0: pop the FIFO, go to D_RELEASE.
- D_RELEASE: ib_tx_data_available=0. On ack_n_s==1: go to D_IDLE.
- ib_tx_data is held constant from D_OFFER entry until the next D_IDLE load.
- Minimum 3 cycles per byte plus synchronizer latency.

Upstream FSM (meter->host):
- U_IDLE: on avail_s==1, capture ib_rx_data into uart_tx_data, go to U_SEND. Capture is safe because the data has been stable for at least SYNC_STAGES cycles.
- U_SEND: uart_tx_valid=1. On uart_tx_ready: go to U_ACK.
- U_ACK: ib_tx_ack=1. On avail_s==0: ib_tx_ack<=0, go to U_IDLE.
- uart_tx_data is unchanged while uart_tx_valid=1.
- The downstream and upstream FSMs are fully independent; simultaneous activity in both directions is legal.

Optional Feature:
- Macro: IB_ACK_TIMEOUT_EN.
- With the macro:
  - A counter runs in D_OFFER, D_RELEASE and U_ACK, clearing on every state change.
  - When the counter reaches TIMEOUT_CYCLES-1: ib_timeout<=1 (sticky until rst).
  - D_OFFER expiry: pop (byte discarded), go to D_IDLE.
  - D_RELEASE expiry: go to D_IDLE.
  - U_ACK expiry: ib_tx_ack<=0, go to U_IDLE.
  - U_SEND never times out.
- Without the macro: no counter logic, ib_timeout=0, and the FSMs wait indefinitely.

Test Plan:
- Reset, then push 0xA5, 0x3C; meter model acks each byte (drops ack_n 4 cycles after available, raises it 4 cycles after available falls) -> ib_tx_data shows 0xA5 then 0x3C in order, each stable throughout its available-high window; FIFO empty at end; overflow=0.
- Push 17 bytes back-to-back with the meter silent (FIFO_DEPTH=16) -> uart_rx_ready=0 after the 16th push (first byte is held in D_OFFER but not popped); 17th byte dropped, overflow=1; acking afterwards delivers bytes 1..16 in order.
- Meter presents ib_rx_data=0x5A with available=1; uart_tx_ready held 0 for 10 cycles -> uart_tx_valid=1 with data 0x5A the whole time, ib_tx_ack=0; after ready: ib_tx_ack=1 until avail_s falls, then 0.
- Both directions active in the same cycles (downstream 0x11, upstream 0x22) -> both bytes delivered correctly, no interference.
- Assert rst during D_OFFER with 3 bytes queued -> next cycle ib_tx_data_available=0, uart_rx_ready=1, FIFO empty, nothing further offered.
- IB_ACK_TIMEOUT_EN with TIMEOUT_CYCLES=50, meter never acks -> available drops after 50 cycles, ib_timeout=1, next queued byte offered.
